spectrum_peak_buf: RTL and testbench

//  Downstream stage of the FFT magnitude (modulus) block. Captures each framed

---
 rtl/spectrum_pkg.sv | 14 +
 rtl/spectrum_peak_buf_if.sv | 28 ++
 rtl/spectrum_dpram.sv | 25 ++
 rtl/spectrum_peak_buf.sv | 139 +++++++++++++
 tb/tb_spectrum_peak_buf.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/spectrum_pkg.sv
// Shared constants and FSM encoding for the spectrum peak buffer.
// Frame length N is 2**ADDR_W; bin 0 is the DC bin.
package spectrum_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int N_DEF      = 1 << ADDR_W_DEF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

endpackage

// File: rtl/spectrum_peak_buf_if.sv
// Magnitude stream in, published-frame readout out.
// Master drives the stream and read address; slave is the peak buffer.
interface spectrum_peak_buf_if #(
  parameter int DATA_W = spectrum_pkg::DATA_W_DEF,
  parameter int ADDR_W = spectrum_pkg::ADDR_W_DEF
);
  logic [DATA_W-1:0] data_modulus;
  logic              data_sop;
  logic              data_eop;
  logic              data_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_bank;
  logic              frame_done;
  logic [DATA_W-1:0] peak_mag;
  logic [ADDR_W-1:0] peak_bin;
  logic              frame_err;

  modport master (
    output data_modulus, data_sop, data_eop, data_valid, rd_addr,
    input  rd_data, rd_bank, frame_done, peak_mag, peak_bin, frame_err
  );

  modport slave (
    input  data_modulus, data_sop, data_eop, data_valid, rd_addr,
    output rd_data, rd_bank, frame_done, peak_mag, peak_bin, frame_err
  );
endinterface

// File: rtl/spectrum_dpram.sv
// Ping-pong frame store: one write port, one registered read port.
// Address MSB selects the bank; the array itself is never reset.
module spectrum_dpram #(
  parameter int DATA_W = 16,
  parameter int AW     = 9
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];

  always_ff @(posedge clk_50m) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
  end
endmodule

// File: rtl/spectrum_peak_buf.sv
// FFT magnitude frame capture with peak-bin tracking and ping-pong publish.
// Optional SPECTRUM_ERR_CNT_EN adds a saturating err_cnt output.
//
// state   | meaning
// ST_IDLE | waiting for sop; samples without sop are dropped
// ST_FILL | writing bins 1..N-1 of the current frame
module spectrum_peak_buf
  import spectrum_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PEAK_START = 1
) (
  input  logic               clk_50m,
  input  logic               rst_n,
`ifdef SPECTRUM_ERR_CNT_EN
  output logic [15:0]        err_cnt,
`endif
  spectrum_peak_buf_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST   = '1;
  localparam logic [ADDR_W-1:0] PSTART = ADDR_W'(PEAK_START);

  state_t            state;
  logic              wbank;
  logic [ADDR_W-1:0] wcnt;
  logic [DATA_W-1:0] run_max;
  logic [ADDR_W-1:0] run_bin;
  logic              rd_bank_q;
  logic              frame_done_q;
  logic              frame_err_q;
  logic [DATA_W-1:0] peak_mag_q;
  logic [ADDR_W-1:0] peak_bin_q;

  logic              start;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] base_max;
  logic [DATA_W-1:0] nxt_max;
  logic [ADDR_W-1:0] base_bin;
  logic [ADDR_W-1:0] nxt_bin;

  // A start sample restarts the peak search, so it compares against a clean base.
  always_comb begin
    start    = bus.data_valid && bus.data_sop;
    we       = bus.data_valid && (start || state == ST_FILL);
    waddr    = start ? '0 : wcnt;
    base_max = start ? '0 : run_max;
    base_bin = start ? PSTART : run_bin;
    nxt_max  = base_max;
    nxt_bin  = base_bin;
    if (waddr >= PSTART && bus.data_modulus > base_max) begin
      nxt_max = bus.data_modulus;
      nxt_bin = waddr;
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      wbank        <= 1'b0;
      wcnt         <= '0;
      run_max      <= '0;
      run_bin      <= PSTART;
      rd_bank_q    <= 1'b1;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
    end else begin
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (we) begin
        run_max <= nxt_max;
        run_bin <= nxt_bin;
      end
      if (bus.data_valid) begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_FILL;
              wcnt  <= 1;
            end
          end
          ST_FILL: begin
            if (start) begin
              frame_err_q <= 1'b1;
              wcnt        <= 1;
            end else if (bus.data_eop) begin
              state <= ST_IDLE;
              if (wcnt == LAST) begin
                rd_bank_q    <= wbank;
                wbank        <= ~wbank;
                peak_mag_q   <= nxt_max;
                peak_bin_q   <= nxt_bin;
                frame_done_q <= 1'b1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end else if (wcnt == LAST) begin
              frame_err_q <= 1'b1;
              state       <= ST_IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  spectrum_dpram #(.DATA_W(DATA_W), .AW(ADDR_W + 1)) u_ram (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   ({wbank, waddr}),
    .wdata   (bus.data_modulus),
    .raddr   ({rd_bank_q, bus.rd_addr}),
    .rdata   (bus.rd_data)
  );

  assign bus.rd_bank    = rd_bank_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.peak_bin   = peak_bin_q;

`ifdef SPECTRUM_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n)                                   err_cnt_q <= '0;
    else if (frame_err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end

  assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_spectrum_peak_buf.sv
// Directed bench for spectrum_peak_buf: frame scoreboard checked on frame_done.
// Covers good/short/restart frames, back-to-back publish and mid-frame reset.
module tb_spectrum_peak_buf;
  logic clk_50m;
  logic rst_n;
`ifdef SPECTRUM_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  spectrum_peak_buf_if bus ();

  spectrum_peak_buf dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
`ifdef SPECTRUM_ERR_CNT_EN
    .err_cnt (err_cnt),
`endif
    .bus     (bus)
  );

  initial clk_50m = 1'b0;
  always #10 clk_50m = ~clk_50m;

  typedef struct {
    int mag;
    int bin;
    int bank;
  } exp_t;

  exp_t q[$];
  int   frm  [256];
  int   pend [256];
  int   pub  [256];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_seen = 0;
  int   err_seen = 0;
  int   exp_bank = 0;
  int   rd_sel = -2;
  int   rd_exp_prev = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    exp_t e;
    if (rd_exp_prev >= 0) check("rd_data", 32'(bus.rd_data), 32'(rd_exp_prev));
    if (bus.frame_done === 1'b1) begin
      done_seen++;
      check("sb_pending", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("peak_mag", 32'(bus.peak_mag), 32'(e.mag));
        check("peak_bin", 32'(bus.peak_bin), 32'(e.bin));
        check("rd_bank", 32'(bus.rd_bank), 32'(e.bank));
        pub = pend;
      end
    end
    if (bus.frame_err === 1'b1) err_seen++;
  endtask

  task automatic step(input logic v, input int d, input logic s, input logic e);
    int a;
    @(negedge clk_50m);
    observe();
    bus.data_valid   = v;
    bus.data_modulus = 16'(d);
    bus.data_sop     = s;
    bus.data_eop     = e;
    rd_exp_prev      = -1;
    if (rd_sel != -2) begin
      a = (rd_sel == -1) ? int'($urandom_range(0, 255)) : rd_sel;
      bus.rd_addr = 8'(a);
      rd_exp_prev = pub[a];
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  // Sends frm[0..len-1]; a 256-bin frame closed by eop is queued as a good frame.
  task automatic send(input int len, input bit with_eop);
    exp_t e;
    for (int k = 0; k < len; k++)
      step(1'b1, frm[k], k == 0, with_eop && (k == len - 1));
    if (with_eop && len == 256) begin
      e.mag = 0;
      e.bin = 1;
      for (int k = 1; k < 256; k++)
        if (frm[k] > e.mag) begin
          e.mag = frm[k];
          e.bin = k;
        end
      e.bank = exp_bank;
      exp_bank ^= 1;
      q.push_back(e);
      pend = frm;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_rd_bank", 32'(bus.rd_bank), 32'd1);
    check("rst_frame_done", 32'(bus.frame_done), 32'd0);
    check("rst_frame_err", 32'(bus.frame_err), 32'd0);
    check("rst_peak_mag", 32'(bus.peak_mag), 32'd0);
    check("rst_peak_bin", 32'(bus.peak_bin), 32'd0);
`ifdef SPECTRUM_ERR_CNT_EN
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
  endtask

  initial begin
    int d0, e0;
    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_modulus = '0;
    bus.data_sop = 1'b0;
    bus.data_eop = 1'b0;
    bus.rd_addr = '0;
    repeat (3) @(negedge clk_50m);
    check_reset_outputs();
    rst_n = 1'b1;
    idle(2);

    // stray samples while idle: ignored, no error
    d0 = done_seen; e0 = err_seen;
    for (int k = 0; k < 4; k++) step(1'b1, 3, 1'b0, k == 3);
    idle(2);
    check("idle_ignore_err", 32'(err_seen - e0), 32'd0);
    check("idle_ignore_done", 32'(done_seen - d0), 32'd0);

    // 1: ramp frame
    d0 = done_seen; e0 = err_seen;
    for (int k = 0; k < 256; k++) frm[k] = k;
    send(256, 1);
    idle(3);
    check("t1_done_cnt", 32'(done_seen - d0), 32'd1);
    check("t1_err_cnt", 32'(err_seen - e0), 32'd0);
    check("t1_peak_const", 32'(bus.peak_mag), 32'd255);
    rd_sel = 37;
    idle(1);
    rd_sel = -2;
    idle(1);

    // 2: DC excluded, lowest index wins tie
    for (int k = 0; k < 256; k++) frm[k] = 1;
    frm[0] = 16'hFFFF; frm[10] = 500; frm[200] = 500;
    send(256, 1);
    idle(3);
    check("t2_peak_mag", 32'(bus.peak_mag), 32'd500);
    check("t2_peak_bin", 32'(bus.peak_bin), 32'd10);

    // 3: short frame
    d0 = done_seen; e0 = err_seen;
    for (int k = 0; k < 256; k++) frm[k] = 4000;
    send(100, 1);
    idle(3);
    check("t3_err_cnt", 32'(err_seen - e0), 32'd1);
    check("t3_done_cnt", 32'(done_seen - d0), 32'd0);
    check("t3_rd_bank", 32'(bus.rd_bank), 32'd1);
    check("t3_peak_mag", 32'(bus.peak_mag), 32'd500);
    check("t3_peak_bin", 32'(bus.peak_bin), 32'd10);
`ifdef SPECTRUM_ERR_CNT_EN
    check("t3_err_cnt_port", 32'(err_cnt), 32'd1);
`endif

    // 4: sop reissued at bin 50, then a full frame
    d0 = done_seen; e0 = err_seen;
    for (int k = 0; k < 256; k++) frm[k] = 5000;
    send(50, 0);
    for (int k = 0; k < 256; k++) frm[k] = 1000 - k;
    send(256, 1);
    idle(3);
    check("t4_err_cnt", 32'(err_seen - e0), 32'd1);
    check("t4_done_cnt", 32'(done_seen - d0), 32'd1);
    rd_sel = 20;
    idle(1);
    rd_sel = 0;
    idle(1);
    rd_sel = -2;
    idle(1);

    // 5: back-to-back frames, reads cross the publish point
    d0 = done_seen; e0 = err_seen;
    for (int k = 0; k < 256; k++) frm[k] = 7;
    send(256, 1);
    for (int k = 0; k < 256; k++) frm[k] = 9;
    rd_sel = -1;
    send(256, 1);
    idle(3);
    rd_sel = -2;
    idle(1);
    check("t5_done_cnt", 32'(done_seen - d0), 32'd2);
    check("t5_err_cnt", 32'(err_seen - e0), 32'd0);
    check("t5_rd_bank", 32'(bus.rd_bank), 32'd0);

    // 6: reset mid-frame
    for (int k = 0; k < 256; k++) frm[k] = 6000;
    send(128, 0);
    @(negedge clk_50m);
    d0 = done_seen; e0 = err_seen;
    rst_n = 1'b0;
    bus.data_valid = 1'b0;
    rd_exp_prev = -1;
    @(negedge clk_50m);
    check_reset_outputs();
    rst_n = 1'b1;
    exp_bank = 0;
    idle(2);
    for (int k = 0; k < 256; k++) frm[k] = 2;
    frm[77] = 300;
    send(256, 1);
    idle(3);
    check("t6_done_cnt", 32'(done_seen - d0), 32'd1);
    check("t6_err_cnt", 32'(err_seen - e0), 32'd0);
    check("t6_peak_bin", 32'(bus.peak_bin), 32'd77);
`ifdef SPECTRUM_ERR_CNT_EN
    check("t6_err_cnt_port", 32'(err_cnt), 32'd0);
`endif
    check("sb_drained", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
